// File: rtl/pifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pifo_pkg
// Brief    : Shared rank/flow types and helpers for the flow-head PIFO scheduler.
// Revision : 1.0
// ============================================================================
package pifo_pkg;

    localparam int RANK_W  = 32;
    localparam int N_FLOWS = 10;

    typedef logic [RANK_W-1:0]  rank_t;
    typedef logic [N_FLOWS-1:0] flow_oh_t;

    function automatic int onehot_to_idx(input flow_oh_t oh);
        int idx;
        idx = 0;
        for (int i = 0; i < N_FLOWS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/min_select.sv
`default_nettype none
// ============================================================================
// Module   : min_select
// Brief    : Combinational unsigned argmin over N (valid, rank) pairs; ties go
//            to the lowest index.
// Revision : 1.0
// ============================================================================
module min_select
    import pifo_pkg::*;
#(
    parameter int N = 10,
    parameter int W = 32
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] rank_i [N],
    output logic [N-1:0] win_o,
    output logic [W-1:0] win_rank_o,
    output logic         any_o
);

    logic [W-1:0] w_best;
    logic         w_found;

    always_comb begin
        win_o   = '0;
        w_best  = '0;
        w_found = 1'b0;
        // Strict less-than keeps the earliest (lowest-index) flow on a tie.
        for (int i = 0; i < N; i++) begin
            if (valid_i[i] && (!w_found || (rank_i[i] < w_best))) begin
                win_o    = '0;
                win_o[i] = 1'b1;
                w_best   = rank_i[i];
                w_found  = 1'b1;
            end
        end
    end

    assign win_rank_o = w_best;
    assign any_o      = |valid_i;

endmodule
`default_nettype wire

// File: rtl/flow_head_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : flow_head_scheduler
// Brief    : PIFO built from per-flow FIFOs: head ranks in registers, tails in
//            an external rank store, min-rank head returned on dequeue.
// Revision : 1.0
// ============================================================================
module flow_head_scheduler #(
    parameter int FLOWS  = pifo_pkg::N_FLOWS,
    parameter int SIZE   = 50,
    parameter int RANK_W = pifo_pkg::RANK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RANK_W-1:0] in_rank,
    input  logic [FLOWS-1:0]  in_flow,
    output logic              deq_ready,
    input  logic              deq_req,
    output logic              deq_valid,
    output logic [RANK_W-1:0] deq_rank,
    output logic [FLOWS-1:0]  deq_flow,
    output logic              rs_push,
    output logic [RANK_W-1:0] rs_push_value,
    output logic [FLOWS-1:0]  rs_push_flow,
    output logic              rs_pop,
    output logic [FLOWS-1:0]  rs_pop_flow,
    input  logic [RANK_W-1:0] rs_pop_value,
    input  logic              rs_pop_valid
);

    localparam int CNT_W = $clog2(SIZE + 1);

    logic [FLOWS-1:0]  head_valid_q, head_valid_d;
    logic [RANK_W-1:0] head_rank_q [FLOWS];
    logic [RANK_W-1:0] head_rank_d [FLOWS];
    logic [CNT_W-1:0]  cnt_q [FLOWS];
    logic [CNT_W-1:0]  cnt_d [FLOWS];
    logic              pend_q, pend_d;
    logic [FLOWS-1:0]  pend_flow_q, pend_flow_d;
    logic              deq_valid_q;
    logic [RANK_W-1:0] deq_rank_q;
    logic [FLOWS-1:0]  deq_flow_q;

    logic [FLOWS-1:0]  w_win;
    logic [RANK_W-1:0] w_win_rank;
    logic              w_any;
    logic [CNT_W-1:0]  w_in_cnt, w_win_cnt;
    logic              w_deq_fire, w_enq_fire;

    min_select #(.N(FLOWS), .W(RANK_W)) u_min_select (
        .valid_i    (head_valid_q),
        .rank_i     (head_rank_q),
        .win_o      (w_win),
        .win_rank_o (w_win_rank),
        .any_o      (w_any)
    );

    always_comb begin
        w_in_cnt  = '0;
        w_win_cnt = '0;
        for (int i = 0; i < FLOWS; i++) begin
            if (in_flow[i]) w_in_cnt  = w_in_cnt  | cnt_q[i];
            if (w_win[i])   w_win_cnt = w_win_cnt | cnt_q[i];
        end
    end

    assign in_ready    = (w_in_cnt < CNT_W'(SIZE));
    assign deq_ready   = w_any && !pend_q;
    assign w_deq_fire  = deq_req && deq_ready;
    assign w_enq_fire  = in_valid && in_ready;
    assign rs_pop      = w_deq_fire && (w_win_cnt != '0);
    assign rs_pop_flow = rs_pop ? w_win : '0;

    always_comb begin
        head_valid_d  = head_valid_q;
        head_rank_d   = head_rank_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        pend_flow_d   = pend_flow_q;
        rs_push       = 1'b0;
        rs_push_flow  = '0;
        rs_push_value = '0;
        for (int i = 0; i < FLOWS; i++) begin
            if (w_deq_fire && w_win[i]) begin
                head_valid_d[i] = 1'b0;
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (rs_pop_valid && pend_q && pend_flow_q[i]) begin
                head_rank_d[i]  = rs_pop_value;
                head_valid_d[i] = 1'b1;
            end
            // Bypass only when nothing older for this flow sits in the store or in flight.
            if (w_enq_fire && in_flow[i]) begin
                if (!head_valid_d[i] && (cnt_q[i] == '0) && !(pend_q && pend_flow_q[i])) begin
                    head_rank_d[i]  = in_rank;
                    head_valid_d[i] = 1'b1;
                end else begin
                    rs_push       = 1'b1;
                    rs_push_flow  = in_flow;
                    rs_push_value = in_rank;
                    cnt_d[i]      = cnt_d[i] + 1'b1;
                end
            end
        end
        if (rs_pop) begin
            pend_d      = 1'b1;
            pend_flow_d = w_win;
        end else if (rs_pop_valid && pend_q) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= '0;
            for (int i = 0; i < FLOWS; i++) begin
                head_rank_q[i] <= '0;
                cnt_q[i]       <= '0;
            end
            pend_q      <= 1'b0;
            pend_flow_q <= '0;
            deq_valid_q <= 1'b0;
            deq_rank_q  <= '0;
            deq_flow_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_rank_q  <= head_rank_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_flow_q  <= pend_flow_d;
            deq_valid_q  <= w_deq_fire;
            if (w_deq_fire) begin
                deq_rank_q <= w_win_rank;
                deq_flow_q <= w_win;
            end
        end
    end

    assign deq_valid = deq_valid_q;
    assign deq_rank  = deq_rank_q;
    assign deq_flow  = deq_flow_q;

    a_in_flow_onehot: assert property (@(posedge clk) disable iff (rst)
        in_valid |-> $onehot(in_flow));

endmodule
`default_nettype wire

// File: tb/tb_flow_head_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_flow_head_scheduler
// Brief    : Directed self-checking bench with a behavioural per-flow rank store.
// Revision : 1.0
// ============================================================================
module tb_flow_head_scheduler;
    import pifo_pkg::*;

    localparam int FLOWS = 10;
    localparam int SIZE  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, deq_ready, deq_req, deq_valid;
    logic [31:0] in_rank, deq_rank, rs_push_value, rs_pop_value;
    logic [9:0]  in_flow, deq_flow, rs_push_flow, rs_pop_flow;
    logic        rs_push, rs_pop, rs_pop_valid;

    logic        m_valid;
    logic [31:0] m_value;
    logic        inj_valid;
    logic [31:0] inj_value;
    logic [31:0] mem [FLOWS][64];
    logic [5:0]  wp [FLOWS];
    logic [5:0]  rp [FLOWS];
    int          pushes_seen, pops_seen;

    int n_tests = 0;
    int n_fail  = 0;
    int pops0;

    always #5 clk = ~clk;

    assign rs_pop_valid = m_valid | inj_valid;
    assign rs_pop_value = inj_valid ? inj_value : m_value;

    flow_head_scheduler #(.FLOWS(FLOWS), .SIZE(SIZE), .RANK_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rank       (in_rank),
        .in_flow       (in_flow),
        .deq_ready     (deq_ready),
        .deq_req       (deq_req),
        .deq_valid     (deq_valid),
        .deq_rank      (deq_rank),
        .deq_flow      (deq_flow),
        .rs_push       (rs_push),
        .rs_push_value (rs_push_value),
        .rs_push_flow  (rs_push_flow),
        .rs_pop        (rs_pop),
        .rs_pop_flow   (rs_pop_flow),
        .rs_pop_value  (rs_pop_value),
        .rs_pop_valid  (rs_pop_valid)
    );

    // Behavioural rank store: per-flow FIFO, pop data one cycle after rs_pop.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                wp[f] <= '0;
                rp[f] <= '0;
            end
            m_valid <= 1'b0;
            m_value <= '0;
        end else begin
            m_valid <= rs_pop;
            if (rs_pop) begin
                m_value <= mem[onehot_to_idx(rs_pop_flow)][rp[onehot_to_idx(rs_pop_flow)]];
                rp[onehot_to_idx(rs_pop_flow)] <= rp[onehot_to_idx(rs_pop_flow)] + 6'd1;
                pops_seen <= pops_seen + 1;
            end
            if (rs_push) begin
                mem[onehot_to_idx(rs_push_flow)][wp[onehot_to_idx(rs_push_flow)]] <= rs_push_value;
                wp[onehot_to_idx(rs_push_flow)] <= wp[onehot_to_idx(rs_push_flow)] + 6'd1;
                pushes_seen <= pushes_seen + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] r, input int f, input logic exp_push);
        in_valid = 1'b1;
        in_rank  = r;
        in_flow  = 10'b1 << f;
        #1;
        chk("enq_in_ready", 64'(in_ready), 64'(1'b1));
        chk("enq_rs_push", 64'(rs_push), 64'(exp_push));
        if (exp_push) begin
            chk("enq_push_flow", 64'(rs_push_flow), 64'(10'b1 << f));
            chk("enq_push_value", 64'(rs_push_value), 64'(r));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic deq_expect(input logic [31:0] r, input int f, input logic exp_ready_after);
        int k;
        k = 0;
        while (!deq_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("deq_ready_wait", 64'(deq_ready), 64'(1'b1));
        deq_req = 1'b1;
        @(posedge clk); #1;
        deq_req = 1'b0;
        chk("deq_valid", 64'(deq_valid), 64'(1'b1));
        chk("deq_rank", 64'(deq_rank), 64'(r));
        chk("deq_flow", 64'(deq_flow), 64'(10'b1 << f));
        chk("deq_ready_after", 64'(deq_ready), 64'(exp_ready_after));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rank = '0; in_flow = 10'b1; deq_req = 1'b0;
        inj_valid = 1'b0; inj_value = '0; pushes_seen = 0; pops_seen = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_deq_valid", 64'(deq_valid), 64'(1'b0));
        chk("rst_deq_rank", 64'(deq_rank), 64'(0));
        chk("rst_deq_flow", 64'(deq_flow), 64'(0));
        chk("rst_deq_ready", 64'(deq_ready), 64'(1'b0));
        chk("rst_rs_push", 64'(rs_push), 64'(1'b0));
        chk("rst_rs_pop", 64'(rs_pop), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk); #1;

        // Single-flow bypass
        enq(32'd7, 0, 1'b0);
        deq_expect(32'd7, 0, 1'b0);
        chk("bypass_no_push", 64'(pushes_seen), 64'(0));

        // Cross-flow ordering
        enq(32'd30, 2, 1'b0);
        enq(32'd10, 5, 1'b0);
        enq(32'd20, 0, 1'b0);
        deq_expect(32'd10, 5, 1'b1);
        deq_expect(32'd20, 0, 1'b1);
        deq_expect(32'd30, 2, 1'b0);

        // Refill from store, FIFO order within a flow
        pops0 = pops_seen;
        enq(32'd5, 1, 1'b0);
        enq(32'd9, 1, 1'b1);
        enq(32'd3, 1, 1'b1);
        enq(32'd4, 3, 1'b0);
        deq_expect(32'd4, 3, 1'b1);
        deq_expect(32'd5, 1, 1'b0);
        deq_expect(32'd9, 1, 1'b0);
        deq_expect(32'd3, 1, 1'b0);
        chk("refill_pop_count", 64'(pops_seen - pops0), 64'(2));

        // Equal ranks resolve to the lower flow index
        enq(32'd12, 4, 1'b0);
        enq(32'd12, 1, 1'b0);
        deq_expect(32'd12, 1, 1'b1);
        deq_expect(32'd12, 4, 1'b0);

        // Fill flow 0 to SIZE+1 ranks
        enq(32'd100, 0, 1'b0);
        for (int i = 1; i <= SIZE; i++) enq(32'd100 + 32'(i), 0, 1'b1);
        in_flow = 10'b1;
        #1;
        chk("full_in_ready_f0", 64'(in_ready), 64'(1'b0));
        in_flow = 10'b10;
        #1;
        chk("full_in_ready_f1", 64'(in_ready), 64'(1'b1));
        in_flow = 10'b1;
        deq_expect(32'd100, 0, 1'b0);
        chk("after_deq_in_ready_f0", 64'(in_ready), 64'(1'b1));
        deq_expect(32'd101, 0, 1'b0);
        deq_expect(32'd102, 0, 1'b0);
        deq_expect(32'd103, 0, 1'b0);
        deq_expect(32'd104, 0, 1'b0);

        // Async reset in the cycle after rs_pop
        rst = 1'b1;
        #1;
        chk("arst_deq_valid", 64'(deq_valid), 64'(1'b0));
        chk("arst_deq_rank", 64'(deq_rank), 64'(0));
        chk("arst_deq_flow", 64'(deq_flow), 64'(0));
        chk("arst_deq_ready", 64'(deq_ready), 64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        inj_valid = 1'b1;
        inj_value = 32'd5;
        @(posedge clk); #1;
        inj_valid = 1'b0;
        #1;
        chk("stale_no_head_load", 64'(deq_ready), 64'(1'b0));
        chk("stale_in_ready", 64'(in_ready), 64'(1'b1));
        enq(32'd8, 0, 1'b0);
        deq_expect(32'd8, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
